// File: rtl/spi_pkg.sv
// Shared types and bus-mode constants for the SPI responder.
`timescale 1ns/1ps
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_e;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus one history flop for edge detection.
`timescale 1ns/1ps
module spi_pin_sync #(
  parameter int SYNC_FF = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] sync_q;
  logic               hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_FF{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], pin};
      hist_q <= sync_q[SYNC_FF-1];
    end
  end

  assign level = sync_q[SYNC_FF-1];
  assign rise  = sync_q[SYNC_FF-1] & ~hist_q;
  assign fall  = ~sync_q[SYNC_FF-1] & hist_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi in the clk domain, receives and
// transmits DATA_W-bit words MSB first, several words per cs_n frame, one-entry tx buffer.
`timescale 1ns/1ps
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Chain and history both reset low: a cs_n already low when reset releases shows no
  // fall, so the responder waits for a fresh select instead of joining a frame midway.
  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin(mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = sclk_lvl | cs_lvl | mosi_rise | mosi_fall;

  spi_state_e        state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sh, tx_sh, tx_buf;
  logic              buf_full, reload_pend;

  logic              smp_edge, shf_edge;
  logic              start_frame, end_frame, do_rise, do_fall, do_load;
  logic [DATA_W-1:0] rx_nx;

  // Mode 0 and mode 3 sample on the rising sclk edge and shift on the falling one.
  assign smp_edge = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
  assign shf_edge = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    do_rise     = 1'b0;
    do_fall     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx    = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nx  = IDLE;
          end_frame = 1'b1;
        end else begin
          do_rise = smp_edge;
          do_fall = shf_edge;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign do_load = start_frame | (do_fall & reload_pend);
  assign rx_nx   = {rx_sh[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      reload_pend <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      // A load consumes the buffer state as it was before this edge.
      if (do_load) begin
        if (buf_full) begin
          tx_sh <= tx_buf;
        end else begin
          tx_sh       <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_fall) begin
        tx_sh <= tx_sh << 1;
      end

      if (do_load && buf_full) begin
        buf_full <= 1'b0;
      end else if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        tx_buf   <= tx_data;
      end

      if (start_frame || end_frame) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        frame_err   <= end_frame && (bit_cnt != '0);
      end else if (do_rise) begin
        rx_sh <= rx_nx;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt     <= '0;
          rx_data     <= rx_nx;
          rx_valid    <= 1'b1;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (do_fall) begin
        reload_pend <= 1'b0;
      end
    end
  end

  assign busy     = (state == ACTIVE);
  assign miso_oe  = (state == ACTIVE);
  assign miso     = (state == ACTIVE) & tx_sh[DATA_W-1];
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: 100 MHz clk, ~9 MHz mode-0 SPI master driven from tasks.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int      DATA_W = 8;
  localparam realtime HALF   = 55.555;

  logic              clk, rst;
  logic              sclk, cs_n, mosi;
  logic              miso, miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, tx_underrun, frame_err, busy;

  spi_responder #(.DATA_W(DATA_W), .SYNC_FF(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor on the falling clk edge, away from the DUT's update edge.
  int        rxv_cnt = 0, urun_cnt = 0, ferr_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) urun_cnt++;
    if (frame_err)   ferr_cnt++;
  end

  // Host-side feeder: offers queued words and pops them once the handshake completes.
  logic [7:0] tx_q[$];
  bit         rdy_d = 1'b0;

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (tx_valid && rdy_d) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
        tx_data  = tx_q[0];
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      rdy_d = tx_ready;
    end
  end

  task automatic wait_q(input int n, input string tag);
    int k = 0;
    while (tx_q.size() > n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, tx_q.size(), n);
    repeat (3) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic mo, output logic mi);
    mosi = mo;
    #(HALF - 1.0);
    mi = miso;
    #1.0;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    logic b;
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      sclk_bit(mo[7-i], b);
      mi[7-i] = b;
    end
  endtask

  task automatic cs_high();
    #(HALF);
    cs_n = 1'b1;
    #(2.0 * HALF);
    @(negedge clk);
  endtask

  logic [7:0] mi, mi2;
  int         b_rx, b_ur, b_fe;
  logic       oe_seen, busy_seen;

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso",     miso, 0);
    chk("rst_miso_oe",  miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data",  rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy",     busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single word
    tx_q.push_back(8'hA5);
    wait_q(0, "t1_preload");
    chk("t1_tx_ready_full", tx_ready, 0);
    b_rx = rxv_cnt; b_fe = ferr_cnt;
    cs_n = 1'b0;
    #(HALF);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_miso_oe", miso_oe, 1);
    xfer(8'h3C, 8, mi);
    cs_high();
    chk("t1_miso_bits", mi, 8'hA5);
    chk("t1_rx_cnt", rxv_cnt - b_rx, 1);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_frame_err", ferr_cnt - b_fe, 0);
    chk("t1_idle_oe", miso_oe, 0);

    // 2: back-to-back words; a third word covers the reload after the last bit
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    wait_q(2, "t2_preload");
    b_rx = rxv_cnt; b_ur = urun_cnt;
    cs_n = 1'b0;
    xfer(8'hF0, 8, mi);
    xfer(8'h0F, 8, mi2);
    cs_high();
    chk("t2_miso_w0", mi, 8'h11);
    chk("t2_miso_w1", mi2, 8'h22);
    chk("t2_rx_cnt", rxv_cnt - b_rx, 2);
    chk("t2_rx_w0", rx_log[b_rx], 8'hF0);
    chk("t2_rx_w1", rx_log[b_rx + 1], 8'h0F);
    chk("t2_underrun", urun_cnt - b_ur, 0);
    chk("t2_q_drained", tx_q.size(), 0);

    // 3: underrun at frame start
    b_rx = rxv_cnt; b_ur = urun_cnt;
    cs_n = 1'b0;
    #40;
    @(negedge clk);
    chk("t3_underrun_start", urun_cnt - b_ur, 1);
    xfer(8'h5A, 8, mi);
    cs_high();
    chk("t3_miso_zero", mi, 8'h00);
    chk("t3_rx_cnt", rxv_cnt - b_rx, 1);
    chk("t3_rx_data", rx_data, 8'h5A);

    // 4: abort after 5 bits, then a full frame
    b_rx = rxv_cnt; b_fe = ferr_cnt;
    cs_n = 1'b0;
    xfer(8'hFF, 5, mi);
    cs_high();
    chk("t4_frame_err", ferr_cnt - b_fe, 1);
    chk("t4_no_rx", rxv_cnt - b_rx, 0);
    chk("t4_rx_held", rx_data, 8'h5A);
    cs_n = 1'b0;
    xfer(8'h81, 8, mi);
    cs_high();
    chk("t4_rx_next", rx_data, 8'h81);
    chk("t4_rx_cnt", rxv_cnt - b_rx, 1);
    chk("t4_ferr_once", ferr_cnt - b_fe, 1);

    // 5: reset mid-frame with cs_n held low
    tx_q.push_back(8'h96);
    wait_q(0, "t5_preload");
    cs_n = 1'b0;
    xfer(8'hFF, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_miso",     miso, 0);
    chk("t5_miso_oe",  miso_oe, 0);
    chk("t5_tx_ready", tx_ready, 1);
    chk("t5_rx_data",  rx_data, 0);
    chk("t5_busy",     busy, 0);
    chk("t5_flags",    {rx_valid, tx_underrun, frame_err}, 0);
    b_rx = rxv_cnt;
    xfer(8'hAA, 8, mi);
    repeat (5) @(negedge clk);
    chk("t5_no_rx", rxv_cnt - b_rx, 0);
    chk("t5_still_idle", busy, 0);
    cs_n = 1'b1;
    #(2.0 * HALF);
    tx_q.push_back(8'h96);
    wait_q(0, "t5_refill");
    cs_n = 1'b0;
    xfer(8'hC3, 8, mi);
    cs_high();
    chk("t5_resume_miso", mi, 8'h96);
    chk("t5_resume_rx", rx_data, 8'hC3);
    chk("t5_resume_cnt", rxv_cnt - b_rx, 1);

    // 6: sclk noise while deselected
    b_rx = rxv_cnt;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      #(HALF);
      oe_seen   = oe_seen | miso_oe | miso;
      busy_seen = busy_seen | busy;
      sclk = 1'b0;
      #(HALF);
    end
    repeat (5) @(negedge clk);
    chk("t6_miso_oe", oe_seen, 0);
    chk("t6_busy", busy_seen, 0);
    chk("t6_no_rx", rxv_cnt - b_rx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
